// File: rtl/vt_buffer_pkg.sv
// vt_buffer_pkg: command codes, FSM states and the default fill
// character shared by the scrolling character buffer.
package vt_buffer_pkg;

    typedef enum logic [1:0] {
        CMD_SCROLL_UP = 2'd0,
        CMD_CLEAR_EOL = 2'd1,
        CMD_CLEAR_EOS = 2'd2,
        CMD_CLEAR_ALL = 2'd3
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;

endpackage

// File: rtl/char_ram.sv
// char_ram: simple dual-port character store, one write port and one
// registered read port (old data on same-address collision), no reset.
module char_ram #(
    parameter int DEPTH     = 1920,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [7:0]           rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/scroll_char_buffer.sv
// scroll_char_buffer: text screen with a rotating first-line register,
// a fill engine for scroll/clear commands and a registered read port.
module scroll_char_buffer
    import vt_buffer_pkg::*;
#(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 24,
    parameter int         ADDR_BITS = 11,
    parameter logic [7:0] FILL_CHAR = FILL_CHAR_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] wrow,
    input  logic [6:0] wcol,
    input  logic [7:0] din,
    input  logic       write_en,
    input  logic [4:0] rrow,
    input  logic [6:0] rcol,
    output logic [7:0] dout,
    input  logic [1:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic       busy
);

    function automatic logic [ADDR_BITS-1:0] map_addr(
        input logic [4:0] row,
        input logic [6:0] col,
        input logic [4:0] top
    );
        logic [5:0] prow;
        prow = {1'b0, row} + {1'b0, top};
        if (prow >= 6'(ROWS)) begin
            prow = prow - 6'(ROWS);
        end
        return ADDR_BITS'(prow) * ADDR_BITS'(COLS) + ADDR_BITS'(col);
    endfunction

    state_e state_q, state_d;
    logic [4:0] top_q, top_d;
    logic [4:0] frow_q, frow_d;
    logic [6:0] fcol_q, fcol_d;
    logic eol_q, eol_d;
    logic init_q, init_d;
    logic oob_q, oob_d;
    logic rvld_q;

    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic [ADDR_BITS-1:0] ram_raddr;
    logic [7:0]           ram_wdata;
    logic [7:0]           ram_rdata;
    logic                 wr_ok;
    logic                 last;

    assign wr_ok = (wrow < 5'(ROWS)) && (wcol < 7'(COLS));
    assign busy = (state_q == ST_FILL);
    assign cmd_ready = !busy;
    assign ram_raddr = map_addr(rrow, rcol, top_q);
    assign oob_d = (rrow >= 5'(ROWS)) || (rcol >= 7'(COLS));
    assign last = (fcol_q == 7'(COLS - 1))
                  && (eol_q || frow_q == 5'(ROWS - 1));

    // RAM output is unreset, so mask it until the first post-reset read.
    assign dout = !rvld_q ? 8'h00 : (oob_q ? FILL_CHAR : ram_rdata);

    always_comb begin
        state_d   = state_q;
        top_d     = top_q;
        frow_d    = frow_q;
        fcol_d    = fcol_q;
        eol_d     = eol_q;
        init_d    = init_q;
        ram_we    = 1'b0;
        ram_waddr = map_addr(wrow, wcol, top_q);
        ram_wdata = din;
        unique case (state_q)
            ST_IDLE: begin
                ram_we = write_en && wr_ok;
                if (init_q) begin
                    init_d  = 1'b0;
                    state_d = ST_FILL;
                    frow_d  = 5'd0;
                    fcol_d  = 7'd0;
                    eol_d   = 1'b0;
                end else if (cmd_valid) begin
                    unique case (cmd_e'(cmd))
                        CMD_SCROLL_UP: begin
                            top_d   = (top_q == 5'(ROWS - 1))
                                      ? 5'd0 : top_q + 5'd1;
                            state_d = ST_FILL;
                            frow_d  = 5'(ROWS - 1);
                            fcol_d  = 7'd0;
                            eol_d   = 1'b1;
                        end
                        CMD_CLEAR_EOL: begin
                            if (wr_ok) begin
                                state_d = ST_FILL;
                                frow_d  = wrow;
                                fcol_d  = wcol;
                                eol_d   = 1'b1;
                            end
                        end
                        CMD_CLEAR_EOS: begin
                            if (wr_ok) begin
                                state_d = ST_FILL;
                                frow_d  = wrow;
                                fcol_d  = wcol;
                                eol_d   = 1'b0;
                            end
                        end
                        CMD_CLEAR_ALL: begin
                            state_d = ST_FILL;
                            frow_d  = 5'd0;
                            fcol_d  = 7'd0;
                            eol_d   = 1'b0;
                        end
                    endcase
                end
            end
            ST_FILL: begin
                ram_we    = 1'b1;
                ram_waddr = map_addr(frow_q, fcol_q, top_q);
                ram_wdata = FILL_CHAR;
                if (last) begin
                    state_d = ST_IDLE;
                end else if (fcol_q == 7'(COLS - 1)) begin
                    fcol_d = 7'd0;
                    frow_d = frow_q + 5'd1;
                end else begin
                    fcol_d = fcol_q + 7'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            top_q   <= 5'd0;
            frow_q  <= 5'd0;
            fcol_q  <= 7'd0;
            eol_q   <= 1'b0;
            init_q  <= 1'b1;
            oob_q   <= 1'b0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            frow_q  <= frow_d;
            fcol_q  <= fcol_d;
            eol_q   <= eol_d;
            init_q  <= init_d;
            oob_q   <= oob_d;
            rvld_q  <= 1'b1;
        end
    end

    char_ram #(
        .DEPTH     (COLS * ROWS),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_scroll_char_buffer.sv
// tb_scroll_char_buffer: logical-screen model plus read scoreboard
// exercising reset clear, writes, scrolls and the clear commands.
module tb_scroll_char_buffer;
    import vt_buffer_pkg::*;

    localparam int COLS = 80;
    localparam int ROWS = 24;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] wrow = '0;
    logic [6:0] wcol = '0;
    logic [7:0] din = '0;
    logic       write_en = 1'b0;
    logic [4:0] rrow = '0;
    logic [6:0] rcol = '0;
    logic [7:0] dout;
    logic [1:0] cmd = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       busy;

    always #5 clk = ~clk;

    scroll_char_buffer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wrow      (wrow),
        .wcol      (wcol),
        .din       (din),
        .write_en  (write_en),
        .rrow      (rrow),
        .rcol      (rcol),
        .dout      (dout),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .busy      (busy)
    );

    typedef struct {
        int         row;
        int         col;
        logic [7:0] exp;
    } rd_t;

    typedef struct {
        int         row;
        int         col;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    rd_t        sb[$];
    bit         rd_issued;
    int         n_chk;
    int         n_err;
    int         scrolls;
    logic [7:0] scr [ROWS][COLS];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        rd_t e;
        @(posedge clk);
        #1;
        if (rd_issued && sb.size() > 0) begin
            rd_issued = 1'b0;
            e = sb.pop_front();
            check($sformatf("read(%0d,%0d)", e.row, e.col), dout, e.exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input int r, input int c);
        if (r >= ROWS || c >= COLS) return 8'h20;
        return scr[r][c];
    endfunction

    function automatic void m_fill(input int r, input int c, input bit eol);
        int last_r;
        if (r >= ROWS || c >= COLS) return;
        last_r = eol ? r : ROWS - 1;
        for (int rr = r; rr <= last_r; rr++)
            for (int cc = (rr == r) ? c : 0; cc < COLS; cc++)
                scr[rr][cc] = 8'h20;
    endfunction

    function automatic void m_scroll();
        for (int r = 0; r < ROWS - 1; r++) scr[r] = scr[r + 1];
        for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = 8'h20;
    endfunction

    task automatic rd(input int r, input int c, input logic [7:0] exp);
        rd_t e;
        rrow = 5'(r);
        rcol = 7'(c);
        e.row = r;
        e.col = c;
        e.exp = exp;
        sb.push_back(e);
        rd_issued = 1'b1;
        tick();
    endtask

    task automatic rd_m(input int r, input int c);
        rd(r, c, model_rd(r, c));
    endtask

    task automatic rd_row(input int r);
        for (int c = 0; c < COLS; c++) rd_m(r, c);
    endtask

    task automatic rd_all();
        for (int r = 0; r < ROWS; r++) rd_row(r);
    endtask

    task automatic wr(input int r, input int c, input logic [7:0] d);
        wrow = 5'(r);
        wcol = 7'(c);
        din = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        if (r < ROWS && c < COLS) scr[r][c] = d;
    endtask

    task automatic m_cmd(input cmd_e code, input int r, input int c);
        unique case (code)
            CMD_SCROLL_UP: begin m_scroll(); scrolls++; end
            CMD_CLEAR_EOL: m_fill(r, c, 1'b1);
            CMD_CLEAR_EOS: m_fill(r, c, 1'b0);
            CMD_CLEAR_ALL: m_fill(0, 0, 1'b0);
        endcase
    endtask

    task automatic cmd_go(input cmd_e code, input int r, input int c);
        cmd = code;
        wrow = 5'(r);
        wcol = 7'(c);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        m_cmd(code, r, c);
    endtask

    task automatic wait_busy(input string name, input int exp_len,
                             input int already);
        int n;
        n = already;
        while (busy && n < 5000) begin
            n++;
            tick();
        end
        check(name, n, exp_len);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{row: 0,  col: 1,   data: 8'h41, exp: 8'h41};
        vecs[1] = '{row: 5,  col: 10,  data: 8'h42, exp: 8'h42};
        vecs[2] = '{row: 23, col: 79,  data: 8'h43, exp: 8'h43};
        vecs[3] = '{row: 12, col: 0,   data: 8'h44, exp: 8'h44};
        vecs[4] = '{row: 24, col: 3,   data: 8'h45, exp: 8'h20};
        vecs[5] = '{row: 3,  col: 80,  data: 8'h46, exp: 8'h20};
        vecs[6] = '{row: 31, col: 127, data: 8'h47, exp: 8'h20};
        vecs[7] = '{row: 10, col: 40,  data: 8'h48, exp: 8'h48};

        n_chk = 0;
        n_err = 0;
        scrolls = 0;
        rd_issued = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;

        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", dout, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_ready", cmd_ready, 1);
        reset_n = 1'b1;
        tick();
        check("init_ready_low", cmd_ready, 0);
        wait_busy("init_clear_len", 1920, 0);
        rd_all();

        foreach (vecs[i]) begin
            wr(vecs[i].row, vecs[i].col, vecs[i].data);
            rd(vecs[i].row, vecs[i].col, vecs[i].exp);
        end
        rd_all();

        wr(0, 0, 8'h41);
        wr(1, 5, 8'h62);
        cmd_go(CMD_SCROLL_UP, 0, 0);
        wait_busy("scroll_len", 80, 0);
        rd(0, 5, 8'h62);
        rd_m(0, 0);
        for (int c = 0; c < COLS; c++) rd(23, c, 8'h20);

        wrow = 5'd23;
        wcol = 7'd79;
        din = 8'h5a;
        write_en = 1'b1;
        cmd = CMD_SCROLL_UP;
        cmd_valid = 1'b1;
        tick();
        write_en = 1'b0;
        cmd_valid = 1'b0;
        scr[23][79] = 8'h5a;
        m_cmd(CMD_SCROLL_UP, 0, 0);
        wait_busy("wr_scroll_len", 80, 0);
        rd(22, 79, 8'h5a);
        for (int c = 0; c < COLS; c++) rd(23, c, 8'h20);

        for (int r = 0; r < ROWS; r++) wr(r, 0, 8'(8'h61 + r));
        for (int i = 0; i < ROWS; i++) begin
            cmd_go(CMD_SCROLL_UP, 0, 0);
            wait_busy($sformatf("scroll%0d_len", i), 80, 0);
            rd_m(23, 0);
            rd_m(22, 0);
        end
        rd_all();

        for (int c = 60; c < COLS; c++) wr(3, c, 8'(8'h30 + c - 60));
        wr(5, 5, 8'h59);
        wr(5, 75, 8'h52);
        cmd_go(CMD_CLEAR_EOL, 3, 70);
        begin
            int n;
            n = 0;
            wrow = 5'd5;
            wcol = 7'd5;
            din = 8'h51;
            write_en = 1'b1;
            cmd = CMD_CLEAR_ALL;
            cmd_valid = 1'b1;
            n++;
            tick();
            n++;
            tick();
            write_en = 1'b0;
            cmd_valid = 1'b0;
            wait_busy("eol_len", 10, n);
        end
        tick();
        check("no_queued_cmd", busy, 0);
        for (int c = 60; c < COLS; c++) rd_m(3, c);
        rd(3, 69, 8'h39);
        rd(5, 5, 8'h59);
        rd_row(5);

        while (scrolls % ROWS != 5) begin
            cmd_go(CMD_SCROLL_UP, 0, 0);
            wait_busy("pre_eos_scroll", 80, 0);
        end
        for (int r = 21; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wr(r, c, 8'(8'h40 + c));
        cmd_go(CMD_CLEAR_EOS, 22, 40);
        wait_busy("eos_len", 120, 0);
        rd_row(21);
        rd_row(22);
        rd_row(23);
        rd(22, 39, 8'h67);
        rd(21, 79, 8'h8f);

        wr(3, 79, 8'h55);
        cmd_go(CMD_CLEAR_EOL, 3, 80);
        wait_busy("eol_oob_len", 0, 0);
        cmd_go(CMD_CLEAR_EOS, 24, 0);
        wait_busy("eos_oob_len", 0, 0);
        rd(3, 79, 8'h55);

        cmd_go(CMD_CLEAR_ALL, 0, 0);
        wait_busy("clear_all_len", 1920, 0);
        rd_all();

        wr(7, 7, 8'h4b);
        cmd_go(CMD_CLEAR_ALL, 0, 0);
        repeat (100) tick();
        reset_n = 1'b0;
        #1;
        check("midfill_reset_busy", busy, 0);
        check("midfill_reset_dout", dout, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        wait_busy("post_reset_clear_len", 1920, 0);
        m_fill(0, 0, 1'b0);
        rd_row(7);
        rd_row(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/scroll_char_buffer.md
SCROLL_CHAR_BUFFER -- requirements
Module: scroll_char_buffer

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per line.
REQ-002 SHALL have parameter ROWS, default 24, lines per screen.
REQ-003 SHALL have parameter ADDR_BITS, default 11, RAM address width, at least clog2(COLS*ROWS).
REQ-004 SHALL have parameter FILL_CHAR, default 8'h20, the character written by clear and scroll fills.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have ports wrow/wcol, input, 5/7, logical write row/column; they are also the command start position.
REQ-008 SHALL have ports din, input, 8, write data; and write_en, input, 1, write strobe.
REQ-009 SHALL have ports rrow/rcol, input, 5/7, logical read row/column; and dout, output, 8, read data.
REQ-010 SHALL have port cmd, input, 2, command code: 0 SCROLL_UP, 1 CLEAR_EOL, 2 CLEAR_EOS, 3 CLEAR_ALL.
REQ-011 SHALL have ports cmd_valid, input, 1; cmd_ready, output, 1, equal to !busy; and busy, output, 1, high while the fill engine runs.

Function
REQ-012 SHALL map logical (row,col) to physical address ((row+top) mod ROWS)*COLS+col, where top is the internal first-line register, range 0..ROWS-1.
REQ-013 SHALL register dout one cycle after rrow/rcol are sampled, using the value of top in the sampling cycle.
REQ-014 SHALL return FILL_CHAR on dout for rrow>=ROWS or rcol>=COLS.
REQ-015 SHALL write din to the mapped address when write_en=1, busy=0, wrow<ROWS and wcol<COLS; it SHALL ignore the write otherwise.
REQ-016 SHALL give read-during-write to the same address old-data behaviour.
REQ-017 SHALL accept a command only when cmd_valid and cmd_ready are both high.
REQ-018 SHALL, if a write and an accepted command occur in the same cycle, complete the write in that cycle and start the fill in the next cycle.
REQ-019 SHALL use FSM states IDLE and FILL; IDLE goes to FILL on command accept; FILL goes to IDLE after the last fill write.
REQ-020 SHALL have busy=1 exactly while the FSM is in FILL, and SHALL write exactly one FILL_CHAR per FILL cycle.
REQ-021 SHALL, on SCROLL_UP, set top to top+1, wrapping ROWS-1 to 0, in the accept cycle, then fill logical row ROWS-1 for COLS cycles.
REQ-022 SHALL, on CLEAR_EOL, fill the captured row from the captured col to COLS-1, taking COLS-col cycles.
REQ-023 SHALL, on CLEAR_EOS, fill from the captured (row,col) in logical order to the end of the screen, taking (ROWS-row)*COLS-col cycles, with physical wrap handled via top.
REQ-024 SHALL, on CLEAR_ALL, fill all ROWS*COLS cells; top is unchanged.
REQ-025 SHALL capture wrow/wcol at command accept; later changes to them SHALL not affect the running fill.
REQ-026 SHALL, if a CLEAR_EOL or CLEAR_EOS start position is out of range, accept the command, perform no writes, and hold busy for 0 cycles.
REQ-027 SHALL ignore cmd_valid while busy=1; commands are not queued.

Reset
REQ-028 SHALL, on reset_n low, asynchronously set top=0, dout=8'h00, FSM=IDLE and the fill counters to 0.
REQ-029 SHALL, on reset_n release, start an automatic CLEAR_ALL; busy=1 for ROWS*COLS cycles starting the first clk edge after release.
REQ-030 SHALL not reset RAM contents directly; a reset mid-fill aborts the fill, and the post-reset clear restores a known state.

Structure
REQ-031 SHALL place the command encodings, FSM state encodings and FILL_CHAR default in shared package vt_buffer_pkg.
REQ-032 SHALL instantiate exactly one sub-module, char_ram: simple dual-port, one write port and one registered read port, depth COLS*ROWS, with no reset.
REQ-033 SHALL contain the address mapping, FSM and fill counters in scroll_char_buffer itself.

Verification
REQ-034 Reset release -> busy=1 for 1920 cycles, then every cell reads 8'h20 and top=0.
REQ-035 Write 'A' at (0,0), then SCROLL_UP -> busy=1 for 80 cycles; (0,0) no longer reads 'A'; row 23 reads 8'h20; data written at (1,5) now reads at (0,5).
REQ-036 Issue 24 consecutive SCROLL_UPs -> top wraps 23 to 0; each scroll clears only the new bottom line.
REQ-037 CLEAR_EOL at (3,70) -> busy for 10 cycles; (3,69) is kept and (3,70..79) read 8'h20; write_en during busy is ignored.
REQ-038 CLEAR_EOS at (22,40) with top=5 -> busy for 120 cycles; row 21 is intact; rows 22 and 23 are cleared from col 40 through the end.
REQ-039 Same-cycle write 'Z' at (23,79) plus SCROLL_UP accept -> 'Z' is visible at (22,79); row 23 is all 8'h20.
